// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: DVP (vsync/href/8-bit data) RGB565 test-pattern source, two bytes per pixel.
module dvp_pattern_tx #(
  parameter int H_PIXEL  = 640,
  parameter int V_PIXEL  = 480,
  parameter int H_BLANK  = 144,
  parameter int VS_LINES = 4,
  parameter int V_BP     = 18,
  parameter int V_FP     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic        busy
);
  localparam int LINE_LEN = 2 * H_PIXEL + H_BLANK;
  localparam int FRAME_LINES = VS_LINES + V_BP + V_PIXEL + V_FP;
  localparam logic [11:0] H_LAST = 12'(LINE_LEN - 1);
  localparam logic [11:0] V_LAST = 12'(FRAME_LINES - 1);
  localparam logic [11:0] V_ACT = 12'(VS_LINES + V_BP);
  localparam logic [11:0] V_END = 12'(VS_LINES + V_BP + V_PIXEL);
  localparam logic [7:0][15:0] BARS = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                       16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};
  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;
  state_t      state_q, state_d;
  logic [11:0] h_q, h_d, v_q, v_d, x, y;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] rgb_q, rgb_d, pix;
  logic [2:0]  bar;
  logic [7:0]  data_d;
  logic        vsync_d, href_d, done_d, busy_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      h_q        <= '0;
      v_q        <= '0;
      pat_q      <= '0;
      rgb_q      <= '0;
      cam_vsync  <= 1'b0;
      cam_href   <= 1'b0;
      cam_data   <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      pat_q      <= pat_d;
      rgb_q      <= rgb_d;
      cam_vsync  <= vsync_d;
      cam_href   <= href_d;
      cam_data   <= data_d;
      frame_done <= done_d;
      busy       <= busy_d;
    end
  // Frame start (from IDLE or straight after the last frame cycle) re-latches the pattern.
  always_comb begin
    state_d = state_q;
    h_d     = '0;
    v_d     = '0;
    pat_d   = pat_q;
    rgb_d   = rgb_q;
    if (state_q == IDLE || (h_q == H_LAST && v_q == V_LAST)) begin
      state_d = en ? VSYNC : IDLE;
      pat_d   = en ? pattern_sel : pat_q;
      rgb_d   = en ? solid_rgb : rgb_q;
    end else begin
      h_d     = (h_q == H_LAST) ? '0 : h_q + 12'd1;
      v_d     = (h_q == H_LAST) ? v_q + 12'd1 : v_q;
      state_d = (v_d < 12'(VS_LINES)) ? VSYNC : (v_d < V_ACT) ? VBP : (v_d < V_END) ? ACTIVE : VFP;
    end
  end
  // Outputs are decoded from next-state values so every output flop lines up with the counters.
  always_comb begin
    x       = {1'b0, h_d[11:1]};
    y       = v_d - V_ACT;
    bar     = 3'(x / 12'(H_PIXEL / 8));
    pix     = (pat_d == 2'd0) ? BARS[bar] : (pat_d == 2'd1) ? 16'(x) + 16'(y) :
              (pat_d == 2'd2) ? rgb_d : {16{x[4] ^ y[4]}};
    vsync_d = state_d == VSYNC;
    href_d  = state_d == ACTIVE && h_d < 12'(2 * H_PIXEL);
    data_d  = href_d ? (h_d[0] ? pix[7:0] : pix[15:8]) : '0;
    done_d  = state_d != IDLE && h_d == H_LAST && v_d == V_LAST;
    busy_d  = state_d != IDLE;
  end
endmodule

// File: tb/tb_dvp_pattern_tx.sv
// tb_dvp_pattern_tx: checks the DVP pattern source against a frame-position reference model.
module tb_dvp_pattern_tx;
  localparam int HP = 8, VP = 4, HB = 4, VS = 1, VB = 1, VF = 1;
  localparam int LL = 2 * HP + HB, FL = VS + VB + VP + VF, FC = LL * FL;
  localparam logic [15:0] BAR_C [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic clk = 0, rst_n = 0, en = 0;
  logic [1:0] pattern_sel = 0;
  logic [15:0] solid_rgb = 0;
  logic cam_vsync, cam_href, frame_done, busy;
  logic [7:0] cam_data;
  int checks = 0, errors = 0;

  dvp_pattern_tx #(.H_PIXEL(HP), .V_PIXEL(VP), .H_BLANK(HB), .VS_LINES(VS), .V_BP(VB), .V_FP(VF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .frame_done(frame_done), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_pix(input logic [1:0] p, input logic [15:0] rgb, input int x, input int y);
    case (p)
      2'd0: return BAR_C[x / (HP / 8)];
      2'd1: return 16'((x + y) % 65536);
      2'd2: return rgb;
      default: return (((x / 16) ^ (y / 16)) % 2) != 0 ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // Reference: position k within a 140-cycle frame, latched pattern, frame-in-progress flag.
  logic m_in = 0;
  int m_k = 0;
  logic [1:0] m_pat = 0;
  logic [15:0] m_rgb = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_in <= 0;
      m_k  <= 0;
    end else if (!m_in || m_k == FC - 1) begin
      m_in <= en;
      m_k  <= 0;
      if (en) begin
        m_pat <= pattern_sel;
        m_rgb <= solid_rgb;
      end
    end else m_k <= m_k + 1;

  // Capture side: rebuild 16-bit words per line, as a cmos_capture_data block would.
  logic [15:0] cap [VP][HP];
  int li = 0, bi = 0, words = 0;
  logic [7:0] hib = 0;
  logic href_prev = 0, vs_prev = 0;
  int cyc = 0;
  int rise_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    href_prev <= cam_href;
    vs_prev   <= cam_vsync;
    if (cam_vsync && !vs_prev) rise_q.push_back(cyc);
    if (cam_vsync) begin
      li <= 0;
      bi <= 0;
      words <= 0;
    end else if (cam_href) begin
      bi <= bi + 1;
      if (bi % 2 == 0) hib <= cam_data;
      else begin
        if (li < VP && bi < 2 * HP) cap[li][bi / 2] <= {hib, cam_data};
        words <= words + 1;
      end
    end else if (href_prev) begin
      li <= li + 1;
      bi <= 0;
    end
  end

  int line, col;
  logic [15:0] e_pix;
  logic e_vs, e_href, e_done;
  logic [7:0] e_data;
  always @(negedge clk)
    if (rst_n) begin
      line   = m_k / LL;
      col    = m_k % LL;
      e_vs   = m_in && line < VS;
      e_href = m_in && line >= VS + VB && line < VS + VB + VP && col < 2 * HP;
      e_pix  = ref_pix(m_pat, m_rgb, col / 2, line - VS - VB);
      e_data = e_href ? ((col % 2) != 0 ? e_pix[7:0] : e_pix[15:8]) : 8'h00;
      e_done = m_in && m_k == FC - 1;
      check("outs{vs,href,data,done,busy}", {20'd0, cam_vsync, cam_href, cam_data, frame_done, busy},
            {20'd0, e_vs, e_href, e_data, e_done, m_in});
      if (e_done) begin
        check("words_per_frame", words, 2 * HP * VP / 2);
        check("href_pulses", li, VP);
      end
    end

  task automatic wait_done(output int n);
    for (int i = 1; i <= 3 * FC; i++) begin
      @(negedge clk);
      if (frame_done) begin
        n = i;
        return;
      end
    end
    n = -1;
  endtask

  typedef struct packed {
    logic [1:0]   pat;
    logic [15:0]  rgb;
    logic [1:0]   y;
    logic [127:0] bytes;
  } vec_t;

  initial begin
    vec_t tbl [5];
    int n;
    tbl[0] = '{2'd0, 16'h0000, 2'd0, 128'hFFFFFFE007FF07E0F81FF800001F0000};
    tbl[1] = '{2'd0, 16'h0000, 2'd3, 128'hFFFFFFE007FF07E0F81FF800001F0000};
    tbl[2] = '{2'd1, 16'h0000, 2'd2, 128'h00020003000400050006000700080009};
    tbl[3] = '{2'd2, 16'hABCD, 2'd1, {8{16'hABCD}}};
    tbl[4] = '{2'd3, 16'h5555, 2'd3, 128'h0};
    repeat (3) @(negedge clk);
    check("reset_outs", {cam_vsync, cam_href, cam_data, frame_done, busy}, 0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    check("idle_no_en", {cam_vsync, busy}, 0);
    for (int i = 0; i < 5; i++) begin
      pattern_sel = tbl[i].pat;
      solid_rgb = tbl[i].rgb;
      en = 1;
      wait_done(n);
      en = 0;
      check($sformatf("tbl%0d_frame_len", i), n, FC);
      for (int w = 0; w < HP; w++)
        check($sformatf("tbl%0d_word%0d", i, w), cap[tbl[i].y][w], tbl[i].bytes[127 - 16 * w -: 16]);
      repeat (3) @(negedge clk);
    end
    pattern_sel = 2;
    solid_rgb = 16'hABCD;
    en = 1;
    repeat (70) @(negedge clk);
    solid_rgb = 16'h1234;
    wait_done(n);
    check("p3_rest_len", n, 70);
    check("p3_f1_first", cap[0][0], 16'hABCD);
    check("p3_f1_last", cap[VP-1][HP-1], 16'hABCD);
    wait_done(n);
    en = 0;
    check("p3_f2_len", n, FC);
    check("p3_f2_word", cap[2][3], 16'h1234);
    repeat (3) @(negedge clk);
    pattern_sel = 1;
    rise_q.delete();
    en = 1;
    for (int f = 0; f < 3; f++) begin
      wait_done(n);
      check($sformatf("p4_f%0d_len", f), n, FC);
    end
    repeat (50) @(negedge clk);
    en = 0;
    wait_done(n);
    check("p4_f4_rest", n, FC - 50);
    @(negedge clk);
    check("p4_busy_low", busy, 0);
    repeat (200) @(negedge clk);
    check("p4_vsync_count", rise_q.size(), 4);
    for (int f = 1; f < 4; f++)
      if (rise_q.size() > f) check($sformatf("p4_vsync_gap%0d", f), rise_q[f] - rise_q[f-1], FC);
    pattern_sel = 0;
    en = 1;
    repeat (4 * LL + 5) @(negedge clk);
    check("p5_href_before_rst", cam_href, 1);
    #2 rst_n = 0;
    #1 check("p5_async_outs", {cam_vsync, cam_href, cam_data, frame_done, busy}, 0);
    @(negedge clk);
    rst_n = 1;
    wait_done(n);
    en = 0;
    check("p5_restart_len", n, FC);
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 3) en = ~en;
      pattern_sel = 2'($urandom);
      solid_rgb = 16'($urandom);
    end
    en = 0;
    repeat (FC + 5) @(negedge clk);
    check("final_idle", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dvp_pattern_tx.md
Name: dvp_pattern_tx

Overview:
- OV7725-style DVP transmitter that generates cam_vsync, cam_href and cam_data[7:0] in RGB565 two-byte-per-pixel format from an internal test-pattern generator.
- It is the source end of the camera capture path. It drives cmos_capture_data directly, with the capture side clocked by the same clk.
- Use: bring-up of the capture/SDRAM/LCD chain without a sensor, and as a bench stimulus source.

Parameters:
- H_PIXEL, 640: active pixels per line (must be a multiple of 8).
- V_PIXEL, 480: active lines per frame.
- H_BLANK, 144: href-low cycles per line.
- VS_LINES, 4: lines for which cam_vsync is high.
- V_BP, 18: blank lines between vsync fall and the first active line.
- V_FP, 10: blank lines after the last active line.

Ports:
- clk  in  1  byte clock; all outputs change on its rising edge (equivalent of cam_pclk).
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  frame generation enable.
- pattern_sel  in  2  0 colour bars, 1 ramp, 2 solid, 3 checkerboard.
- solid_rgb  in  16  RGB565 colour used when pattern_sel=2.
- cam_vsync  out  1  frame sync, active high.
- cam_href  out  1  line valid, active high.
- cam_data  out  8  pixel byte.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- busy  out  1  high whenever a frame is in progress.

Behaviour:
- Reset (async, rst_n low): all outputs 0, FSM in IDLE, counters cleared. Release is taken on the next clk edge.
- Derived values: LINE_LEN = 2*H_PIXEL + H_BLANK; FRAME_LINES = VS_LINES + V_BP + V_PIXEL + V_FP. Counters are h_cnt (0..LINE_LEN-1) and v_cnt (0..FRAME_LINES-1), 12 bits each. h_cnt wraps at LINE_LEN-1 and then increments v_cnt.
- FSM states: IDLE -> VSYNC -> VBP -> ACTIVE -> VFP -> (VSYNC or IDLE).
  - IDLE: en sampled high at an edge. On the following cycle cam_vsync=1, h_cnt=0, v_cnt=0, busy=1. pattern_sel and solid_rgb are latched at this point and held for the whole frame.
  - VSYNC: cam_vsync high for exactly VS_LINES*LINE_LEN cycles.
  - VBP: V_BP*LINE_LEN cycles with all outputs low.
  - ACTIVE: V_PIXEL lines. In each line, cam_href=1 for h_cnt 0..2*H_PIXEL-1, then 0 for H_BLANK cycles.
  - VFP: V_FP*LINE_LEN cycles idle.
  - End of VFP: the last cycle of the frame is frame_done=1. On the next cycle, if en=1 the FSM enters VSYNC (back-to-back frames, no gap) and re-latches the pattern; otherwise it enters IDLE with busy=0.
- en deassert mid-frame: the current frame completes fully, then IDLE. Frames are never truncated.
- Pixel byte order: pixel x = h_cnt>>1. Even h_cnt outputs pixel[15:8], odd h_cnt outputs pixel[7:0]. cam_data=0 whenever cam_href=0.
- Pixel value per pattern, with y = active line index 0..V_PIXEL-1:
  - Pattern 0: 8 bars of width H_PIXEL/8. Bar index = x/(H_PIXEL/8). Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Pattern 1: (x + y) mod 65536.
  - Pattern 2: solid_rgb.
  - Pattern 3: FFFF if (x[4] XOR y[4]) else 0000.
- Timing alignment: cam_href, cam_vsync and cam_data are all registered and mutually aligned, with zero skew between them.
- Counts: exactly 2*H_PIXEL href-high cycles per line and exactly V_PIXEL href pulses per frame.

Test Plan:
Bench parameters for all scenarios: H_PIXEL=8, V_PIXEL=4, H_BLANK=4, VS_LINES=1, V_BP=1, V_FP=1. This gives LINE_LEN=20, 7 lines per frame, 140 cycles per frame.
1. Reset, then en=1, pattern 0 -> vsync high 20 cycles; 20 idle cycles; then 4 lines of 16 href cycles separated by 4 low cycles. Each line carries bytes FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00. frame_done pulses once at cycle 140.
2. Pattern 1 -> line y=2 bytes are 00 02, 00 03, ..., 00 09. No other bytes appear while href is high.
3. Pattern 2 with solid_rgb=ABCD, then solid_rgb changed to 1234 mid-frame -> the entire frame outputs AB CD pairs. The next frame outputs 12 34.
4. en held high for 3 frames -> vsync rises exactly 140 cycles apart and frame_done pulses 3 times. en dropped at cycle 50 of frame 4 -> frame 4 completes, busy=0 from cycle 141, and no further vsync.
5. rst_n asserted during ACTIVE line 2 -> all outputs 0 immediately (asynchronous). After release with en=1, a fresh frame starts with vsync.
6. Cross-check with cmos_capture_data driven from the same clk -> captured 16-bit words match the expected pattern. Exactly 32 words per frame after its startup frames.
